exec_writeback: RTL and testbench
=================================

# exec_writeback

Execute-and-writeback unit that consumes the operand dispatch from `control` (`data_a`, `data_b`, `func`, `store`), performs the 32-bit add or a sequential Vedic 16x16 multiply, and returns the result to the t0–t8 register file through a single write port. It sits between the control/decode stage and the register holding registers that feed `control`'s `t*ss` inputs. It closes the `control` loop with an issue/busy handshake.

## Interface
Parameters:
- `W`, 32, operand/result width (fixed at 32; other values unsupported)
- `NREG`, 9, number of architectural registers (codes 1..NREG)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `issue`  in  1  one-cycle strobe: dispatch fields are valid this cycle
- `data_a`  in  32  operand A
- `data_b`  in  32  operand B
- `func`  in  3  0 = nop, 1 = add, 2 = mpy, 3–7 = illegal
- `store`  in  5  destination register code (t0 = 1 … t8 = 9)
- `busy`  out  1  unit occupied; `issue` ignored while high
- `wr_en`  out  1  register-file write strobe, one cycle
- `wr_addr`  out  5  destination code, valid with `wr_en`
- `wr_data`  out  32  result, valid with `wr_en`
- `done`  out  1  one-cycle pulse at writeback, also for suppressed writes
- `err`  out  1  one-cycle pulse: illegal `func` or destination outside 1..NREG

## Operation
- FSM states: IDLE, ADD, MUL, WB.
- IDLE + `issue`: latch `data_a`, `data_b`, `func`, `store`.
  - func 1 → ADD.
  - func 2 → MUL; clear accumulator; pp index = 0.
  - func 0 → stay IDLE; no write, no `done`.
  - func 3–7 → stay IDLE; `err` pulses the next cycle.
- ADD (1 cycle): acc = A + B, modulo 2^32 (carry discarded) → WB.
- MUL (4 cycles): multiplies the low 16 bits of A by the low 16 bits of B. Upper 16 bits of both operands are ignored.
  - Vedic split: aH·bH, aH·bL, aL·bH, aL·bL (8x8 each).
  - One partial product per cycle, in index order 0..3 = LL, LH, HL, HH.
  - Each is shifted by 0/8/8/16 and added to a 32-bit acc.
  - After index 3 → WB. The result is exact; it never exceeds 32 bits.
- WB (1 cycle): `wr_data` = acc, `wr_addr` = latched `store`, `done` = 1.
  - `wr_en` = 1 only if `store` is in 1..NREG.
  - Otherwise `wr_en` = 0 and `err` = 1.
  - Next state → IDLE.
- `busy` = (state != IDLE), registered.
- `issue` while `busy` is ignored entirely: no latch, no `err`.
- `issue` in the WB cycle is also ignored. `busy` is still high in that cycle.

## Timing
- Reset values: `busy`, `wr_en`, `done`, `err` = 0; `wr_addr` = 0; `wr_data` = 0; acc = 0; state = IDLE.
- `rst` asserted mid-operation aborts immediately. No write occurs, and the pending result is lost.
- Issue is sampled at edge k.
  - `busy` is high from after edge k until after the WB cycle.
  - Add: `wr_en`/`done` high in the cycle after edge k+2.
  - Mpy: `wr_en`/`done` high in the cycle after edge k+5.
- Earliest back-to-back issue is at edge k+3 (add) or k+6 (mpy), the first edge where `busy` is low.
- `wr_addr`/`wr_data` hold their last values outside WB.
- `err` for an illegal `func` is high in the cycle after edge k.

## Configuration
- `EXWB_SAT_ADD_EN` defined: on carry-out, the add result saturates to 0xFFFFFFFF.
- `EXWB_SAT_ADD_EN` undefined: the add result wraps modulo 2^32.
- Multiply behaviour is identical in both builds.

## Test plan
- Add: issue func=1, A=0x25, B=0x1B, store=3 → 2 cycles later `wr_en`=1, `wr_addr`=3, `wr_data`=0x40, `done`=1, for exactly one cycle.
- Mpy: issue func=2, A=0x00FF, B=0x00FF, store=5 → 5 cycles later `wr_data`=0xFE01, `wr_addr`=5. Also A=0xFFFF, B=0xFFFF → 0xFFFE0001. Also A=0x1234_0003, B=0x0004 → 0x0000000C (upper bits ignored).
- Busy rule: issue mpy, then issue add (A=1, B=1, store=2) one cycle later → only the mpy writes back; no second `wr_en`; `busy` low in the cycle after WB.
- Wrap vs. saturate: add A=0xFFFFFFFF, B=2 → `wr_data`=0x00000001 without the macro, 0xFFFFFFFF with `EXWB_SAT_ADD_EN`.
- Errors:
  - func=5 → `err` pulse; `busy` stays 0; no `done`.
  - add with store=12 → `done`=1, `err`=1, `wr_en`=0.
  - func=0 → no outputs change.
- Reset mid-mpy: assert `rst` 2 cycles after issue → `busy`=0 immediately; no `wr_en` ever. A subsequent add issue completes normally.

Source files
------------

// File: rtl/exec_writeback.sv
// Execute/writeback unit: 32-bit add or sequential 4-step Vedic 16x16 multiply, one register-file write port.
// Optional build macro EXWB_SAT_ADD_EN: add saturates to all-ones on carry-out instead of wrapping.
module exec_writeback #(
   parameter int W    = 32,
   parameter int NREG = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         issue,
   input  logic [W-1:0] data_a,
   input  logic [W-1:0] data_b,
   input  logic [2:0]   func,
   input  logic [4:0]   store,
   output logic         busy,
   output logic         wr_en,
   output logic [4:0]   wr_addr,
   output logic [W-1:0] wr_data,
   output logic         done,
   output logic         err
);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_MUL, S_WB} state_t;

   localparam logic [2:0] FUNC_ADD = 3'd1;
   localparam logic [2:0] FUNC_MPY = 3'd2;
   localparam logic [4:0] MAX_ADDR = 5'(NREG);

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [4:0]     store_q, store_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [1:0]     idx_q, idx_d;
   logic           busy_q, busy_d;
   logic           wr_en_q, wr_en_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic [4:0]     wr_addr_q, wr_addr_d;
   logic [W-1:0]   wr_data_q, wr_data_d;
   logic           store_ok;

   function automatic logic [W-1:0] add_op(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef EXWB_SAT_ADD_EN
      logic [W:0] s;
      s = {1'b0, x} + {1'b0, y};
      return s[W] ? '1 : s[W-1:0];
`else
      return x + y;
`endif
   endfunction

   // Partial products in order LL, LH, HL, HH with weights 2^0, 2^8, 2^8, 2^16.
   function automatic logic [W-1:0] vedic_pp(input logic [1:0] idx, input logic [15:0] a,
                                             input logic [15:0] b);
      logic [15:0]  p;
      logic [W-1:0] pw;
      case (idx)
         2'd0:    p = a[7:0]  * b[7:0];
         2'd1:    p = a[7:0]  * b[15:8];
         2'd2:    p = a[15:8] * b[7:0];
         default: p = a[15:8] * b[15:8];
      endcase
      pw = {{(W-16){1'b0}}, p};
      case (idx)
         2'd0:    return pw;
         2'd3:    return pw << 16;
         default: return pw << 8;
      endcase
   endfunction

   assign store_ok = (store_q != 5'd0) && (store_q <= MAX_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (issue) begin
            if (func == FUNC_ADD)      state_d = S_ADD;
            else if (func == FUNC_MPY) state_d = S_MUL;
         end
         S_ADD:   state_d = S_WB;
         S_MUL:   if (idx_q == 2'd3) state_d = S_WB;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_q == S_WB);
      wr_en_d   = (state_q == S_WB) && store_ok;
      err_d     = ((state_q == S_IDLE) && issue && (func > FUNC_MPY)) ||
                  ((state_q == S_WB) && !store_ok);
      wr_addr_d = (state_q == S_WB) ? store_q : wr_addr_q;
      wr_data_d = (state_q == S_WB) ? acc_q : wr_data_q;
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      store_d = store_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: if (issue) begin
            a_d     = data_a;
            b_d     = data_b;
            store_d = store;
            if (func == FUNC_MPY) begin
               acc_d = '0;
               idx_d = 2'd0;
            end
         end
         S_ADD: acc_d = add_op(a_q, b_q);
         S_MUL: begin
            acc_d = acc_q + vedic_pp(idx_q, a_q[15:0], b_q[15:0]);
            idx_d = idx_q + 2'd1;
         end
         default: ;
      endcase
   end

   // Operand latches carry no reset; they are always reloaded before use.
   always_ff @(posedge clk) begin
      a_q     <= a_d;
      b_q     <= b_d;
      store_q <= store_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q     <= '0;
         idx_q     <= 2'd0;
         busy_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         wr_addr_q <= 5'd0;
         wr_data_q <= '0;
      end else begin
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         busy_q    <= busy_d;
         wr_en_q   <= wr_en_d;
         done_q    <= done_d;
         err_q     <= err_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign busy    = busy_q;
   assign wr_en   = wr_en_q;
   assign done    = done_q;
   assign err     = err_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_exec_writeback.sv
// Directed bench for exec_writeback: vector table for add/mpy results and latency, plus hand sequences.
module tb_exec_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue;
   logic [31:0] data_a, data_b;
   logic [2:0]  func;
   logic [4:0]  store;
   logic        busy, wr_en, done, err;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int n_tests = 0;
   int n_fail  = 0;

   exec_writeback #(.W(32), .NREG(9)) dut (
      .clk(clk), .rst(rst), .issue(issue), .data_a(data_a), .data_b(data_b),
      .func(func), .store(store), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  func;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  store;
      logic [31:0] exp_data;
      logic        exp_wr_en;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic drive_issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] s);
      func   = f;
      data_a = a;
      data_b = b;
      store  = s;
      issue  = 1'b1;
      @(negedge clk);
      issue  = 1'b0;
   endtask

   task automatic run_vec(input int i, input vec_t v);
      int lat = 0;
      wait_idle();
      drive_issue(v.func, v.a, v.b, v.store);
      chk($sformatf("v%0d_busy_after_issue", i), 32'(busy), 32'd1);
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(v.exp_wr_en));
      chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(v.store));
      chk($sformatf("v%0d_wr_data", i), wr_data, v.exp_data);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(v.exp_err));
      chk($sformatf("v%0d_busy_at_wb_out", i), 32'(busy), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_wr_en_one_cycle", i), 32'(wr_en), 32'd0);
      chk($sformatf("v%0d_wr_data_hold", i), wr_data, v.exp_data);
   endtask

   initial begin
      int cnt_wr, cnt_done, cnt_err;

      vecs[0] = '{3'd1, 32'h0000_0025, 32'h0000_001B, 5'd3,  32'h0000_0040, 1'b1, 1'b0, 2};
      vecs[1] = '{3'd2, 32'h0000_00FF, 32'h0000_00FF, 5'd5,  32'h0000_FE01, 1'b1, 1'b0, 5};
      vecs[2] = '{3'd2, 32'h0000_FFFF, 32'h0000_FFFF, 5'd9,  32'hFFFE_0001, 1'b1, 1'b0, 5};
      vecs[3] = '{3'd2, 32'h1234_0003, 32'h0000_0004, 5'd1,  32'h0000_000C, 1'b1, 1'b0, 5};
`ifdef EXWB_SAT_ADD_EN
      vecs[4] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4,  32'hFFFF_FFFF, 1'b1, 1'b0, 2};
`else
      vecs[4] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4,  32'h0000_0001, 1'b1, 1'b0, 2};
`endif
      vecs[5] = '{3'd1, 32'h0000_0001, 32'h0000_0002, 5'd12, 32'h0000_0003, 1'b0, 1'b1, 2};
      vecs[6] = '{3'd2, 32'hABCD_1234, 32'h0000_5678, 5'd7,  32'h0626_0060, 1'b1, 1'b0, 5};
      vecs[7] = '{3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 5'd2,  32'hFFFF_FFFF, 1'b1, 1'b0, 2};
      vecs[8] = '{3'd2, 32'h0000_0003, 32'h0000_0005, 5'd0,  32'h0000_000F, 1'b0, 1'b1, 5};

      rst = 1'b1; issue = 1'b0; func = 3'd0; data_a = '0; data_b = '0; store = '0;
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_wr_en", 32'(wr_en), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      chk("reset_wr_addr", 32'(wr_addr), 32'd0);
      chk("reset_wr_data", wr_data, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // func 0: nothing happens, outputs hold the last writeback values.
      drive_issue(3'd0, 32'h5555_5555, 32'h1, 5'd3);
      cnt_wr = 0; cnt_done = 0; cnt_err = 0;
      for (int c = 0; c < 6; c++) begin
         if (busy) cnt_err += 100;
         if (wr_en) cnt_wr++;
         if (done) cnt_done++;
         if (err) cnt_err++;
         @(negedge clk);
      end
      chk("nop_no_wr_en", 32'(cnt_wr), 32'd0);
      chk("nop_no_done", 32'(cnt_done), 32'd0);
      chk("nop_no_err_no_busy", 32'(cnt_err), 32'd0);
      chk("nop_wr_addr_hold", 32'(wr_addr), 32'd0);
      chk("nop_wr_data_hold", wr_data, 32'h0000_000F);

      // Illegal func: one err pulse the cycle after issue, never busy or done.
      drive_issue(3'd5, 32'h1, 32'h1, 5'd3);
      chk("illegal_err_pulse", 32'(err), 32'd1);
      chk("illegal_busy", 32'(busy), 32'd0);
      chk("illegal_done", 32'(done), 32'd0);
      cnt_err = 0; cnt_done = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (err) cnt_err++;
         if (done || busy) cnt_done++;
      end
      chk("illegal_err_one_cycle", 32'(cnt_err), 32'd0);
      chk("illegal_no_done_busy", 32'(cnt_done), 32'd0);

      // Issue while busy is ignored: only the multiply writes back.
      drive_issue(3'd2, 32'h3, 32'h7, 5'd6);
      func = 3'd1; data_a = 32'h1; data_b = 32'h1; store = 5'd2; issue = 1'b1;
      @(negedge clk);
      issue = 1'b0;
      cnt_wr = 0;
      for (int c = 0; c < 12; c++) begin
         if (wr_en) begin
            cnt_wr++;
            chk("busy_rule_wr_addr", 32'(wr_addr), 32'd6);
            chk("busy_rule_wr_data", wr_data, 32'd21);
            chk("busy_rule_busy_low_after_wb", 32'(busy), 32'd0);
         end
         @(negedge clk);
      end
      chk("busy_rule_single_write", 32'(cnt_wr), 32'd1);

      // Reset two cycles into a multiply aborts it with no write.
      drive_issue(3'd2, 32'h00FF, 32'h00FF, 5'd5);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_wr_data", wr_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cnt_wr = 0; cnt_done = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (wr_en) cnt_wr++;
         if (done) cnt_done++;
      end
      chk("midrst_no_wr_en", 32'(cnt_wr), 32'd0);
      chk("midrst_no_done", 32'(cnt_done), 32'd0);
      run_vec(100, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
